// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline hazard controller. It detects load-use hazards between the
//   instructions in ID and EX, flushes the wrong-path instructions after a
//   taken branch, and sequences a multi-cycle mul/div unit. While that unit
//   is busy the front of the pipeline is held. A watchdog aborts an
//   operation that never reports completion.
//
// Ports
//   clk                         pipeline clock, rising edge
//   reset_n                     asynchronous active-low reset
//   rs1_id, rs2_id [4:0]        source registers of the instruction in ID
//   rd_ex [4:0]                 destination register of the instruction in EX
//   memread_ex                  instruction in EX is a load
//   branch_taken_ex             taken branch/jump resolved in EX
//   mdu_req_ex                  instruction in EX is a multi-cycle mul/div op
//   mdu_done                    one-cycle pulse: multi-cycle result is valid
//   stall_if/id/ex              hold PC, IF/ID, ID/EX (combinational)
//   flush_id/ex/mem             bubble into IF/ID, ID/EX, EX/MEM (combinational)
//   mdu_start                   one-cycle start pulse to the multi-cycle unit
//   mdu_timeout                 sticky watchdog flag (registered)
//   stall_count [15:0]          saturating count of cycles with stall_if=1
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic [4:0]  rd_ex,
    input  logic        memread_ex,
    input  logic        branch_taken_ex,
    input  logic        mdu_req_ex,
    input  logic        mdu_done,
    output logic        stall_if,
    output logic        stall_id,
    output logic        stall_ex,
    output logic        flush_id,
    output logic        flush_ex,
    output logic        flush_mem,
    output logic        mdu_start,
    output logic        mdu_timeout,
    output logic [15:0] stall_count
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  busy_cnt;
    logic        lu;
    logic        timeout_hit;

    // Register x0 is hard-wired zero, so a load targeting it never hazards.
    assign lu = memread_ex && (rd_ex != 5'd0) &&
                ((rd_ex == rs1_id) || (rd_ex == rs2_id));

    // Outputs are forced low while reset is asserted, independent of state.
    always_comb begin
        state_nxt   = state;
        stall_if    = 1'b0;
        stall_id    = 1'b0;
        stall_ex    = 1'b0;
        flush_id    = 1'b0;
        flush_ex    = 1'b0;
        flush_mem   = 1'b0;
        mdu_start   = 1'b0;
        timeout_hit = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    // Priority: multi-cycle op, then branch, then load-use.
                    if (mdu_req_ex) begin
                        mdu_start = 1'b1;
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                        state_nxt = BUSY;
                    end else if (branch_taken_ex) begin
                        flush_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (lu) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                BUSY: begin
                    // Completion and watchdog expiry both release the pipe
                    // in the same cycle with all controls low.
                    if (mdu_done) begin
                        state_nxt = IDLE;
                    end else if (busy_cnt == 8'hFF) begin
                        timeout_hit = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        stall_ex  = 1'b1;
                        flush_mem = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counts BUSY cycles; the first BUSY cycle sees 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_cnt <= '0;
        end else if (state == IDLE && state_nxt == BUSY) begin
            busy_cnt <= '0;
        end else if (state == BUSY) begin
            busy_cnt <= busy_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdu_timeout <= 1'b0;
        end else if (timeout_hit) begin
            mdu_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_if && stall_count != '1) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule
